// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI request/response structs, DTM op codes and DMI error codes.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMINoError       = 2'h0,
        DMIReservedError = 2'h1,
        DMIOPFailed      = 2'h2,
        DMIBusy          = 2'h3
    } dmi_error_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_access_ctrl_pkg.sv
// Local definitions for the DTM-side DMI access controller.
package dmi_access_ctrl_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned OpW   = 2;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Read      = 3'd1,
        WaitRead  = 3'd2,
        Write     = 3'd3,
        WaitWrite = 3'd4
    } state_e;

endpackage

// File: rtl/dmi_access_ctrl.sv
// Converts JTAG DMI-register updates into single DMI transactions and keeps the sticky op status.
module dmi_access_ctrl
    import dm::*;
    import dmi_access_ctrl_pkg::*;
#(
    parameter int unsigned AbitsDmi = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dr_update_i,
    input  logic                   dr_capture_i,
    input  logic [AbitsDmi+33:0]   dr_wdata_i,
    output logic [AbitsDmi+33:0]   dr_rdata_o,
    input  logic                   dmireset_i,
    input  logic                   dmihardreset_i,
    output logic [1:0]             dmistat_o,
    output logic                   dmi_rst_no,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    output dmi_req_t               dmi_req_o,
    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o,
    input  dmi_resp_t              dmi_resp_i
);

    state_e              state_q, state_d;
    logic [AbitsDmi-1:0] addr_q;
    logic [DataW-1:0]    data_q;
    dmi_error_e          status_q;
    logic                rst_n_q;

    logic [AbitsDmi-1:0] upd_addr;
    logic [DataW-1:0]    upd_data;
    logic [OpW-1:0]      upd_op;
    logic                accept;
    logic                busy_hit;
    logic                resp_fire;

    assign upd_addr = dr_wdata_i[AbitsDmi+33:DataW+OpW];
    assign upd_data = dr_wdata_i[DataW+OpW-1:OpW];
    assign upd_op   = dr_wdata_i[OpW-1:0];

    // Both reset flavours take precedence over a coincident update.
    assign accept    = dr_update_i && (state_q == Idle) && (status_q == DMINoError)
                       && !dmireset_i && !dmihardreset_i;
    assign busy_hit  = (dr_update_i || dr_capture_i) && (state_q != Idle);
    assign resp_fire = dmi_resp_valid_i && dmi_resp_ready_o && !dmihardreset_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        dmi_req_o.addr   = addr_q;
        dmi_req_o.op     = DTM_NOP;
        dmi_req_o.data   = data_q;
        unique case (state_q)
            Idle: begin
                if (accept && upd_op == DTM_READ) begin
                    state_d = Read;
                end else if (accept && upd_op == DTM_WRITE) begin
                    state_d = Write;
                end
            end
            Read: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_o.op    = DTM_READ;
                if (dmi_req_ready_i) state_d = WaitRead;
            end
            Write: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_o.op    = DTM_WRITE;
                if (dmi_req_ready_i) state_d = WaitWrite;
            end
            WaitRead, WaitWrite: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
        if (dmihardreset_i) state_d = Idle;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            data_q   <= '0;
            status_q <= DMINoError;
            rst_n_q  <= 1'b1;
        end else begin
            rst_n_q <= !dmihardreset_i;
            if (dmihardreset_i || dmireset_i) begin
                status_q <= DMINoError;
            end else if (status_q == DMINoError) begin
                if (resp_fire && dmi_resp_i.resp != 2'b00) begin
                    status_q <= DMIOPFailed;
                end else if (busy_hit) begin
                    status_q <= DMIBusy;
                end
            end
            if (accept) begin
                addr_q <= upd_addr;
                if (upd_op == DTM_WRITE) data_q <= upd_data;
            end
            if (resp_fire && state_q == WaitRead) begin
                data_q <= dmi_resp_i.data;
            end
        end
    end

    assign dr_rdata_o = {addr_q, data_q, status_q};
    assign dmistat_o  = status_q;
    assign dmi_rst_no = rst_n_q;

    // The TAP can only be in one of Capture-DR / Update-DR at a time.
    update_capture_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dr_update_i && dr_capture_i));

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed bench for dmi_access_ctrl: hand-driven DMI handshakes with fixed expected values.
module tb_dmi_access_ctrl;
    import dm::*;

    localparam int AW = 7;
    localparam int DW = AW + 34;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          dr_update_i;
    logic          dr_capture_i;
    logic [DW-1:0] dr_wdata_i;
    logic [DW-1:0] dr_rdata_o;
    logic          dmireset_i;
    logic          dmihardreset_i;
    logic [1:0]    dmistat_o;
    logic          dmi_rst_no;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    dmi_req_t      dmi_req_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    dmi_resp_t     dmi_resp_i;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    dmi_access_ctrl #(.AbitsDmi(AW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dr_update_i      (dr_update_i),
        .dr_capture_i     (dr_capture_i),
        .dr_wdata_i       (dr_wdata_i),
        .dr_rdata_o       (dr_rdata_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmistat_o        (dmistat_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i)
    );

    function automatic logic [DW-1:0] dr(input logic [AW-1:0] a, input logic [31:0] d,
                                         input logic [1:0] o);
        return {a, d, o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic update(input logic [DW-1:0] w);
        dr_wdata_i  = w;
        dr_update_i = 1'b1;
        tick();
        dr_update_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_i       = '{data: d, resp: r};
        dmi_resp_valid_i = 1'b1;
        tick();
        dmi_resp_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni           = 1'b0;
        dr_update_i      = 1'b0;
        dr_capture_i     = 1'b0;
        dr_wdata_i       = '0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '{data: 32'h0, resp: 2'b00};
        tick();
        tick();
        chk("rst_req_valid", dmi_req_valid_o, 0);
        chk("rst_resp_ready", dmi_resp_ready_o, 0);
        chk("rst_dmi_rst_n", dmi_rst_no, 1);
        chk("rst_status", dmistat_o, 0);
        chk("rst_rdata", dr_rdata_o, 0);
        rst_ni = 1'b1;
        tick();

        // 1: write 0x1 to 0x10
        update(dr(7'h10, 32'h1, 2'd2));
        chk("t1_req_valid", dmi_req_valid_o, 1);
        chk("t1_req", dmi_req_o, {7'h10, 2'd2, 32'h1});
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        chk("t1_valid_drop", dmi_req_valid_o, 0);
        chk("t1_resp_ready", dmi_resp_ready_o, 1);
        respond(32'h0, 2'b00);
        chk("t1_idle_resp_ready", dmi_resp_ready_o, 0);
        chk("t1_rdata", dr_rdata_o, dr(7'h10, 32'h1, 2'd0));

        // 2: read 0x04 with ready stalled 3 cycles; read keeps data_q in the request
        update(dr(7'h04, 32'h55, 2'd1));
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_valid", dmi_req_valid_o, 1);
            chk("t2_stall_req", dmi_req_o, {7'h04, 2'd1, 32'h1});
            tick();
        end
        dmi_req_ready_i = 1'b1;
        chk("t2_req_at_ready", dmi_req_o, {7'h04, 2'd1, 32'h1});
        tick();
        dmi_req_ready_i = 1'b0;
        chk("t2_resp_ready", dmi_resp_ready_o, 1);
        respond(32'hDEADBEEF, 2'b00);
        chk("t2_rdata", dr_rdata_o, dr(7'h04, 32'hDEADBEEF, 2'd0));

        // 3: second update during WaitRead -> busy; busy sticks over a failed response
        update(dr(7'h08, 32'h0, 2'd1));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        update(dr(7'h20, 32'hAAAA, 2'd2));
        chk("t3_busy_status", dmistat_o, 3);
        chk("t3_no_extra_req", dmi_req_valid_o, 0);
        chk("t3_still_waiting", dmi_resp_ready_o, 1);
        respond(32'h12345678, 2'b10);
        chk("t3_rdata", dr_rdata_o, dr(7'h08, 32'h12345678, 2'd3));
        update(dr(7'h30, 32'hBBBB, 2'd2));
        chk("t3_ignored_valid", dmi_req_valid_o, 0);
        chk("t3_ignored_addr", dr_rdata_o, dr(7'h08, 32'h12345678, 2'd3));
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        chk("t3_dmireset", dmistat_o, 0);

        // 4: failed response, then a capture keeps status 2
        update(dr(7'h0C, 32'h0, 2'd1));
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        respond(32'hA5, 2'b10);
        chk("t4_opfailed", dmistat_o, 2);
        dr_capture_i = 1'b1;
        tick();
        dr_capture_i = 1'b0;
        chk("t4_capture_keeps", dr_rdata_o, dr(7'h0C, 32'hA5, 2'd2));
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        chk("t4_cleared", dmistat_o, 0);
        // dmireset coincident with update drops the update
        dmireset_i = 1'b1;
        update(dr(7'h15, 32'h0, 2'd1));
        dmireset_i = 1'b0;
        chk("t4_coincident_valid", dmi_req_valid_o, 0);
        tick();
        chk("t4_coincident_valid2", dmi_req_valid_o, 0);
        chk("t4_coincident_addr", dr_rdata_o, dr(7'h0C, 32'hA5, 2'd0));

        // 5: hardreset during stalled write
        update(dr(7'h40, 32'h99, 2'd2));
        chk("t5_valid", dmi_req_valid_o, 1);
        dr_capture_i = 1'b1;
        tick();
        dr_capture_i = 1'b0;
        chk("t5_busy", dmistat_o, 3);
        chk("t5_inflight", dmi_req_o, {7'h40, 2'd2, 32'h99});
        dmihardreset_i = 1'b1;
        chk("t5_rst_n_before", dmi_rst_no, 1);
        tick();
        dmihardreset_i = 1'b0;
        chk("t5_rst_n_low", dmi_rst_no, 0);
        chk("t5_valid_drop", dmi_req_valid_o, 0);
        chk("t5_status_clr", dmistat_o, 0);
        tick();
        chk("t5_rst_n_back", dmi_rst_no, 1);
        chk("t5_still_idle", dmi_req_valid_o, 0);

        // 6: NOP and reserved op latch addr only
        update(dr(7'h11, 32'h777, 2'd0));
        chk("t6_nop_valid", dmi_req_valid_o, 0);
        chk("t6_nop_rdata", dr_rdata_o, dr(7'h11, 32'h99, 2'd0));
        update(dr(7'h22, 32'h888, 2'd3));
        chk("t6_rsv_valid", dmi_req_valid_o, 0);
        tick();
        chk("t6_rsv_valid2", dmi_req_valid_o, 0);
        chk("t6_rsv_rdata", dr_rdata_o, dr(7'h22, 32'h99, 2'd0));

        // reset asserted mid-transaction
        update(dr(7'h50, 32'h5, 2'd2));
        chk("mid_valid", dmi_req_valid_o, 1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("mid_rst_valid", dmi_req_valid_o, 0);
        chk("mid_rst_rdata", dr_rdata_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
